// File: rtl/fft_radix2_top.sv
// Iterative in-place radix-2 DIT FFT: bit-reversed load, one butterfly per clock,
// natural-order streamed output of the N complex bins.
module fft_radix2_top #(
    parameter int unsigned N = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        new_data,
    input  logic [$clog2(N)-1:0]        addr,
    input  logic signed [31:0]          data_in_real,
    input  logic signed [31:0]          data_in_imag,
    output logic [$clog2(N)-1:0]        addr_out,
    output logic signed [31:0]          data_out_real,
    output logic signed [31:0]          data_out_imag,
    output logic                        valid
);
    localparam int unsigned AW = $clog2(N);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned JW = AW - 1;
    localparam int unsigned SW = $clog2(AW);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COMPUTE, S_OUTPUT} state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [SW-1:0]      r_stage;
    logic [JW-1:0]      r_bfly;
    logic signed [31:0] r_ram_re [N];
    logic signed [31:0] r_ram_im [N];

    logic [AW-1:0]      w_h, w_k, w_grp, w_top, w_bot;
    logic [4:0]         w_tw_idx;
    logic signed [31:0] w_wr, w_wi, w_ar, w_ai, w_br, w_bi, w_tr, w_ti;
    logic signed [31:0] w_top_re, w_top_im, w_bot_re, w_bot_im;

    // Quarter-wave cosine table on a 64-point grid; any N<=64 indexes it with a stride.
    function automatic logic signed [31:0] qcos(input logic [4:0] m);
        case (m)
            5'd0:    qcos = 32'sd32768;
            5'd1:    qcos = 32'sd32610;
            5'd2:    qcos = 32'sd32138;
            5'd3:    qcos = 32'sd31357;
            5'd4:    qcos = 32'sd30274;
            5'd5:    qcos = 32'sd28899;
            5'd6:    qcos = 32'sd27246;
            5'd7:    qcos = 32'sd25330;
            5'd8:    qcos = 32'sd23170;
            5'd9:    qcos = 32'sd20788;
            5'd10:   qcos = 32'sd18205;
            5'd11:   qcos = 32'sd15447;
            5'd12:   qcos = 32'sd12540;
            5'd13:   qcos = 32'sd9512;
            5'd14:   qcos = 32'sd6393;
            5'd15:   qcos = 32'sd3212;
            default: qcos = 32'sd0;
        endcase
    endfunction

    function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
        logic [AW-1:0] r;
        for (int i = 0; i < int'(AW); i++) r[i] = a[int'(AW) - 1 - i];
        return r;
    endfunction

    // Butterfly datapath: index math, twiddle lookup, complex multiply, add/sub.
    always_comb begin
        w_h      = AW'(1) << r_stage;
        w_k      = AW'(r_bfly) & (w_h - AW'(1));
        w_grp    = AW'(r_bfly >> r_stage);
        w_top    = AW'(w_grp << (32'(r_stage) + 32'd1)) | w_k;
        w_bot    = w_top + w_h;
        w_tw_idx = 5'(32'(w_k) << (32'd5 - 32'(r_stage)));
        if (w_tw_idx <= 5'd16) begin
            w_wr = qcos(w_tw_idx);
            w_wi = -qcos(5'd16 - w_tw_idx);
        end else begin
            w_wr = -qcos(5'(6'd32 - {1'b0, w_tw_idx}));
            w_wi = -qcos(w_tw_idx - 5'd16);
        end
        w_ar = r_ram_re[w_top];
        w_ai = r_ram_im[w_top];
        w_br = r_ram_re[w_bot];
        w_bi = r_ram_im[w_bot];
        w_tr = 32'((64'(w_br) * 64'(w_wr) - 64'(w_bi) * 64'(w_wi)) >>> 15);
        w_ti = 32'((64'(w_br) * 64'(w_wi) + 64'(w_bi) * 64'(w_wr)) >>> 15);
        w_top_re = w_ar + w_tr;
        w_top_im = w_ai + w_ti;
        w_bot_re = w_ar - w_tr;
        w_bot_im = w_ai - w_ti;
    end

    // Sample RAM: contents are not reset, only the control path is.
    always_ff @(posedge clk) begin
        if (!rst && r_state == S_LOAD) begin
            r_ram_re[bitrev(addr)] <= data_in_real;
            r_ram_im[bitrev(addr)] <= data_in_imag;
        end else if (!rst && r_state == S_COMPUTE) begin
            r_ram_re[w_top] <= w_top_re;
            r_ram_im[w_top] <= w_top_im;
            r_ram_re[w_bot] <= w_bot_re;
            r_ram_im[w_bot] <= w_bot_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_stage       <= '0;
            r_bfly        <= '0;
            valid         <= 1'b0;
            addr_out      <= '0;
            data_out_real <= '0;
            data_out_imag <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (new_data) begin
                        r_state <= S_LOAD;
                        r_cnt   <= '0;
                    end
                end
                S_LOAD: begin
                    r_cnt <= r_cnt + CW'(1);
                    if (r_cnt == CW'(N - 1)) begin
                        r_state <= S_COMPUTE;
                        r_cnt   <= '0;
                        r_stage <= '0;
                        r_bfly  <= '0;
                    end
                end
                S_COMPUTE: begin
                    if (r_bfly == JW'(N / 2 - 1)) begin
                        r_bfly <= '0;
                        if (r_stage == SW'(AW - 1)) begin
                            r_stage <= '0;
                            r_cnt   <= '0;
                            r_state <= S_OUTPUT;
                        end else begin
                            r_stage <= r_stage + SW'(1);
                        end
                    end else begin
                        r_bfly <= r_bfly + JW'(1);
                    end
                end
                S_OUTPUT: begin
                    if (r_cnt == CW'(N)) begin
                        valid         <= 1'b0;
                        addr_out      <= '0;
                        data_out_real <= '0;
                        data_out_imag <= '0;
                        r_cnt         <= '0;
                        r_state       <= S_IDLE;
                    end else begin
                        valid         <= 1'b1;
                        addr_out      <= AW'(r_cnt);
                        data_out_real <= r_ram_re[AW'(r_cnt)];
                        data_out_imag <= r_ram_im[AW'(r_cnt)];
                        r_cnt         <= r_cnt + CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_radix2_top.sv
// Directed bench for fft_radix2_top (N=16): impulse, DC, alternating, cosine,
// reset abort, ignored start pulses and back-to-back transforms.
module tb_fft_radix2_top;
    logic               clk = 1'b0;
    logic               rst;
    logic               new_data;
    logic [3:0]         addr;
    logic signed [31:0] data_in_real;
    logic signed [31:0] data_in_imag;
    logic [3:0]         addr_out;
    logic signed [31:0] data_out_real;
    logic signed [31:0] data_out_imag;
    logic               valid;

    int n_cmp  = 0;
    int n_fail = 0;

    logic signed [31:0] x_re [16];
    logic signed [31:0] x_im [16];
    int                 y_re [16];
    int                 y_im [16];
    int                 exp_re [16];
    int                 exp_im [16];

    fft_radix2_top #(.N(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .new_data      (new_data),
        .addr          (addr),
        .data_in_real  (data_in_real),
        .data_in_imag  (data_in_imag),
        .addr_out      (addr_out),
        .data_out_real (data_out_real),
        .data_out_imag (data_out_imag),
        .valid         (valid)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input int obs, input int lo, input int hi);
        n_cmp++;
        assert (obs >= lo && obs <= hi) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // Caller sits on a negedge; start is raised here, samples follow on the next 16 cycles.
    task automatic start_and_load(input bit poke);
        new_data = 1'b1;
        for (int n = 0; n < 16; n++) begin
            @(negedge clk);
            new_data     = poke && n[0];
            addr         = 4'(n);
            data_in_real = x_re[n];
            data_in_imag = x_im[n];
        end
        @(negedge clk);
        new_data     = 1'b0;
        addr         = '0;
        data_in_real = '0;
        data_in_imag = '0;
    endtask

    // Waits for the first bin, captures all 16, then checks the return to idle outputs.
    task automatic collect(input string tag, input bit poke);
        int waited = 0;
        while (valid !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_latency"}, 16 + waited, 48, 52);
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("%s_valid[%0d]", tag, b), int'(valid), 1, 1);
            chk($sformatf("%s_addr[%0d]", tag, b), int'(addr_out), b, b);
            y_re[b] = data_out_real;
            y_im[b] = data_out_imag;
            new_data = poke && (b == 5);
            @(negedge clk);
        end
        new_data = 1'b0;
        chk({tag, "_valid_end"}, int'(valid), 0, 0);
        chk({tag, "_re_end"}, data_out_real, 0, 0);
        chk({tag, "_addr_end"}, int'(addr_out), 0, 0);
    endtask

    task automatic check_bins(input string tag, input int tol);
        for (int b = 0; b < 16; b++) begin
            chk($sformatf("%s_re[%0d]", tag, b), y_re[b], exp_re[b] - tol, exp_re[b] + tol);
            chk($sformatf("%s_im[%0d]", tag, b), y_im[b], exp_im[b] - tol, exp_im[b] + tol);
        end
    endtask

    task automatic set_dc;
        for (int n = 0; n < 16; n++) begin
            x_re[n] = 100; x_im[n] = 0;
            exp_re[n] = (n == 0) ? 1600 : 0; exp_im[n] = 0;
        end
    endtask

    task automatic set_impulse;
        for (int n = 0; n < 16; n++) begin
            x_re[n] = (n == 0) ? 1000 : 0; x_im[n] = 0;
            exp_re[n] = 1000; exp_im[n] = 0;
        end
    endtask

    initial begin
        bit seen;
        rst = 1'b1; new_data = 1'b0; addr = '0;
        data_in_real = '0; data_in_imag = '0;
        repeat (2) @(negedge clk);
        chk("rst_valid", int'(valid), 0, 0);
        chk("rst_addr", int'(addr_out), 0, 0);
        chk("rst_re", data_out_real, 0, 0);
        chk("rst_im", data_out_imag, 0, 0);
        rst = 1'b0;
        @(negedge clk);

        // Impulse with start toggling during LOAD and a pulse during OUTPUT.
        set_impulse();
        start_and_load(1'b1);
        collect("imp", 1'b1);
        check_bins("imp", 0);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen |= valid;
        end
        chk("imp_no_restart", int'(seen), 0, 0);

        // DC, then alternating launched on the very first idle cycle.
        set_dc();
        start_and_load(1'b0);
        collect("dc", 1'b0);
        check_bins("dc", 0);
        for (int n = 0; n < 16; n++) begin
            x_re[n] = n[0] ? -1000 : 1000; x_im[n] = 0;
            exp_re[n] = (n == 8) ? 16000 : 0; exp_im[n] = 0;
        end
        start_and_load(1'b0);
        collect("alt", 1'b0);
        check_bins("alt", 0);

        // Rounded Q15 cosine at bin 1.
        x_re = '{32768, 30274, 23170, 12540, 0, -12540, -23170, -30274,
                 -32768, -30274, -23170, -12540, 0, 12540, 23170, 30274};
        for (int n = 0; n < 16; n++) begin
            x_im[n] = 0;
            exp_re[n] = (n == 1 || n == 15) ? 262144 : 0; exp_im[n] = 0;
        end
        start_and_load(1'b0);
        collect("cos", 1'b0);
        check_bins("cos", 16);

        // Abort an impulse transform mid-compute, then a fresh DC run.
        set_impulse();
        start_and_load(1'b0);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_valid", int'(valid), 0, 0);
        chk("abort_re", data_out_real, 0, 0);
        chk("abort_addr", int'(addr_out), 0, 0);
        seen = 1'b0;
        repeat (60) begin
            @(negedge clk);
            seen |= valid;
        end
        chk("abort_no_output", int'(seen), 0, 0);
        set_dc();
        start_and_load(1'b0);
        collect("dc2", 1'b0);
        check_bins("dc2", 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
